// File: rtl/decoder_n_scan.sv
// decoder_n_scan: registered N-to-2**N decoder with one-hot DECODE,
// thermometer THERM, a dwell-timed SCAN sequencer and a HOLD mode.
// All outputs come straight from flops; the next-state logic is one
// combinational block feeding one register block.
module decoder_n_scan #(
    parameter int N     = 3,
    parameter int DWELL = 10   // cycles per SCAN step, 1..65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [N-1:0]        X,
    input  logic                load,
    output logic [(2**N)-1:0]   Y,
    output logic [N-1:0]        idx,
    output logic                wrap
);

    localparam int M  = 2 ** N;
    // A one-cycle dwell still needs a 1-bit counter to stay a legal vector.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]  IDX_MAX    = N'(M - 1);

    typedef enum logic [1:0] {
        MODE_DECODE = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    mode_t          mode_e;
    logic [CW-1:0]  cnt, cnt_n;
    logic [M-1:0]   y_n;
    logic [N-1:0]   idx_n;
    logic           wrap_n;
    // Set while the dwell counter is counting a live SCAN period. Clearing
    // it outside SCAN makes the first SCAN edge after any other mode restart
    // the period and re-encode Y from the current index.
    logic           in_scan, in_scan_n;

    assign mode_e = mode_t'(mode);

    function automatic logic [M-1:0] one_hot(input logic [N-1:0] sel);
        one_hot      = '0;
        one_hot[sel] = 1'b1;
    endfunction

    function automatic logic [M-1:0] thermo(input logic [N-1:0] sel);
        for (int i = 0; i < M; i++)
            thermo[i] = (i <= int'(sel));
    endfunction

    // Next-state logic: everything holds unless en=1, wrap is a pulse.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch can be inferred.
        y_n       = Y;
        idx_n     = idx;
        cnt_n     = cnt;
        wrap_n    = 1'b0;
        in_scan_n = in_scan;
        if (en) begin
            case (mode_e)
                MODE_DECODE: begin
                    idx_n     = X;
                    y_n       = one_hot(X);
                    cnt_n     = '0;
                    in_scan_n = 1'b0;
                end
                MODE_THERM: begin
                    idx_n     = X;
                    y_n       = thermo(X);
                    cnt_n     = '0;
                    in_scan_n = 1'b0;
                end
                MODE_SCAN: begin
                    in_scan_n = 1'b1;
                    if (load) begin
                        // Load beats any coincident step or wrap.
                        idx_n = X;
                        y_n   = one_hot(X);
                        cnt_n = '0;
                    end else if (!in_scan) begin
                        y_n   = one_hot(idx);
                        cnt_n = '0;
                    end else if (cnt == DWELL_LAST) begin
                        cnt_n  = '0;
                        idx_n  = idx + N'(1);
                        y_n    = one_hot(idx + N'(1));
                        wrap_n = (idx == IDX_MAX);
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                MODE_HOLD: begin
                    in_scan_n = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // State register; reset looks like a SCAN load of index 0, so a scan
    // right after release runs a full dwell before its first step.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values regardless of statement order.
        if (rst) begin
            Y       <= M'(1);
            idx     <= '0;
            wrap    <= 1'b0;
            cnt     <= '0;
            in_scan <= 1'b1;
        end else begin
            Y       <= y_n;
            idx     <= idx_n;
            wrap    <= wrap_n;
            cnt     <= cnt_n;
            in_scan <= in_scan_n;
        end
    end

endmodule

// File: tb/tb_decoder_n_scan.sv
// Bench for decoder_n_scan: instance a is N=3/DWELL=4, instance b is
// N=4/DWELL=1. Expected outputs are queued as stimulus is driven and
// compared against outputs captured one cycle later.
module tb_decoder_n_scan;

    localparam logic [1:0] M_DEC   = 2'b00;
    localparam logic [1:0] M_THERM = 2'b01;
    localparam logic [1:0] M_SCAN  = 2'b10;
    localparam logic [1:0] M_HOLD  = 2'b11;

    typedef struct packed {
        logic [7:0] y;
        logic [2:0] idx;
        logic       wrap;
    } out_t;

    typedef struct packed {
        logic [15:0] y;
        logic [3:0]  idx;
        logic        wrap;
    } out_b_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, load;
    logic [1:0]  mode;
    logic [2:0]  X;
    logic [7:0]  Y;
    logic [2:0]  idx;
    logic        wrap;
    logic        en_b, load_b;
    logic [1:0]  mode_b;
    logic [3:0]  x_b;
    logic [15:0] y_b;
    logic [3:0]  idx_b;
    logic        wrap_b;

    int checks = 0;
    int errors = 0;

    out_t   exp_q[$], obs_q[$];
    out_b_t exp_b_q[$], obs_b_q[$];

    always #5 clk = ~clk;

    decoder_n_scan #(.N(3), .DWELL(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .X(X), .load(load),
        .Y(Y), .idx(idx), .wrap(wrap)
    );

    decoder_n_scan #(.N(4), .DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .X(x_b), .load(load_b),
        .Y(y_b), .idx(idx_b), .wrap(wrap_b)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1);
    end

    // Drive one cycle of stimulus on dut_a, queue what it must show after
    // the coming edge, and capture what it does show.
    task automatic drive(input logic e, input logic [1:0] m, input logic [2:0] xv,
                         input logic ld, input logic [7:0] ey, input logic [2:0] ei,
                         input logic ew);
        en = e; mode = m; X = xv; load = ld;
        exp_q.push_back(out_t'({ey, ei, ew}));
        @(posedge clk); #1;
        obs_q.push_back(out_t'({Y, idx, wrap}));
    endtask

    function automatic logic [7:0] oh(input int i);
        logic [7:0] one = 8'b1;
        return one << i;
    endfunction

    task automatic test_reset();
        out_t e, o;
        int n = 0;
        checks++;
        if ({Y, idx, wrap} !== {8'b0000_0001, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_a: got Y=%b idx=%0d wrap=%b, want Y=00000001 idx=0 wrap=0", Y, idx, wrap);
        end
        checks++;
        if ({y_b, idx_b, wrap_b} !== {16'h0001, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_b: got Y=%h idx=%0d wrap=%b, want Y=0001 idx=0 wrap=0", y_b, idx_b, wrap_b);
        end
        rst = 1'b0;
        drive(1, M_DEC, 3'd5, 1'b0, 8'b0010_0000, 3'd5, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL first_edge[%0d]: got Y=%b idx=%0d wrap=%b, want Y=%b idx=%0d wrap=%b",
                         n, o.y, o.idx, o.wrap, e.y, e.idx, e.wrap);
            end
            n++;
        end
    endtask

    task automatic test_decode();
        out_t e, o;
        int n = 0;
        for (int x = 0; x < 8; x++)
            for (int k = 0; k < 10; k++)
                drive(1, M_DEC, 3'(x), k[0], oh(x), 3'(x), 1'b0);
        drive(0, M_DEC, 3'd3, 1'b0, 8'b1000_0000, 3'd7, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL decode[%0d]: got Y=%b idx=%0d wrap=%b, want Y=%b idx=%0d wrap=%b",
                         n, o.y, o.idx, o.wrap, e.y, e.idx, e.wrap);
            end
            n++;
        end
    endtask

    task automatic test_therm();
        out_t e, o;
        int n = 0;
        logic [7:0] ones = 8'hFF;
        for (int x = 0; x < 8; x++)
            drive(1, M_THERM, 3'(x), 1'b1, ones >> (7 - x), 3'(x), 1'b0);
        drive(1, M_THERM, 3'd3, 1'b0, 8'b0000_1111, 3'd3, 1'b0);
        drive(0, M_THERM, 3'd7, 1'b0, 8'b0000_1111, 3'd3, 1'b0);
        drive(0, M_THERM, 3'd7, 1'b0, 8'b0000_1111, 3'd3, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL therm[%0d]: got Y=%b idx=%0d wrap=%b, want Y=%b idx=%0d wrap=%b",
                         n, o.y, o.idx, o.wrap, e.y, e.idx, e.wrap);
            end
            n++;
        end
    endtask

    task automatic test_scan();
        out_t e, o;
        int n = 0;
        drive(1, M_SCAN, 3'd6, 1'b1, oh(6), 3'd6, 1'b0);
        for (int k = 0; k < 3; k++) drive(1, M_SCAN, 3'd0, 1'b0, oh(6), 3'd6, 1'b0);
        for (int k = 0; k < 4; k++) drive(1, M_SCAN, 3'd0, 1'b0, oh(7), 3'd7, 1'b0);
        drive(1, M_SCAN, 3'd0, 1'b0, oh(0), 3'd0, 1'b1);
        for (int k = 0; k < 3; k++) drive(1, M_SCAN, 3'd0, 1'b0, oh(0), 3'd0, 1'b0);
        drive(1, M_SCAN, 3'd0, 1'b0, oh(1), 3'd1, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL scan[%0d]: got Y=%b idx=%0d wrap=%b, want Y=%b idx=%0d wrap=%b",
                         n, o.y, o.idx, o.wrap, e.y, e.idx, e.wrap);
            end
            n++;
        end
    endtask

    // Load on the wrapping edge, then an en=0 pause in the middle of a dwell.
    task automatic test_back_to_back();
        out_t e, o;
        int n = 0;
        drive(1, M_SCAN, 3'd7, 1'b1, oh(7), 3'd7, 1'b0);
        for (int k = 0; k < 3; k++) drive(1, M_SCAN, 3'd0, 1'b0, oh(7), 3'd7, 1'b0);
        drive(1, M_SCAN, 3'd2, 1'b1, oh(2), 3'd2, 1'b0);
        drive(1, M_SCAN, 3'd0, 1'b0, oh(2), 3'd2, 1'b0);
        for (int k = 0; k < 5; k++) drive(0, M_SCAN, 3'd0, 1'b0, oh(2), 3'd2, 1'b0);
        for (int k = 0; k < 2; k++) drive(1, M_SCAN, 3'd0, 1'b0, oh(2), 3'd2, 1'b0);
        drive(1, M_SCAN, 3'd0, 1'b0, oh(3), 3'd3, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got Y=%b idx=%0d wrap=%b, want Y=%b idx=%0d wrap=%b",
                         n, o.y, o.idx, o.wrap, e.y, e.idx, e.wrap);
            end
            n++;
        end
    endtask

    // Entry into SCAN from THERM and from HOLD restarts the dwell.
    task automatic test_mode_entry();
        out_t e, o;
        int n = 0;
        drive(1, M_THERM, 3'd2, 1'b0, 8'b0000_0111, 3'd2, 1'b0);
        for (int k = 0; k < 4; k++) drive(1, M_SCAN, 3'd6, 1'b0, oh(2), 3'd2, 1'b0);
        drive(1, M_SCAN, 3'd0, 1'b0, oh(3), 3'd3, 1'b0);
        drive(1, M_SCAN, 3'd0, 1'b0, oh(3), 3'd3, 1'b0);
        for (int k = 0; k < 2; k++) drive(1, M_HOLD, 3'd5, 1'b1, oh(3), 3'd3, 1'b0);
        for (int k = 0; k < 4; k++) drive(1, M_SCAN, 3'd0, 1'b0, oh(3), 3'd3, 1'b0);
        drive(1, M_SCAN, 3'd0, 1'b0, oh(4), 3'd4, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mode_entry[%0d]: got Y=%b idx=%0d wrap=%b, want Y=%b idx=%0d wrap=%b",
                         n, o.y, o.idx, o.wrap, e.y, e.idx, e.wrap);
            end
            n++;
        end
    endtask

    // Asynchronous reset between edges in the middle of a scan.
    task automatic test_reset_midscan();
        out_t e, o;
        int n = 0;
        drive(1, M_SCAN, 3'd5, 1'b1, oh(5), 3'd5, 1'b0);
        drive(1, M_SCAN, 3'd0, 1'b0, oh(5), 3'd5, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({Y, idx, wrap} !== {8'b0000_0001, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got Y=%b idx=%0d wrap=%b, want Y=00000001 idx=0 wrap=0", Y, idx, wrap);
        end
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) drive(1, M_SCAN, 3'd0, 1'b0, oh(0), 3'd0, 1'b0);
        drive(1, M_SCAN, 3'd0, 1'b0, oh(1), 3'd1, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_midscan[%0d]: got Y=%b idx=%0d wrap=%b, want Y=%b idx=%0d wrap=%b",
                         n, o.y, o.idx, o.wrap, e.y, e.idx, e.wrap);
            end
            n++;
        end
    endtask

    // N=4, DWELL=1: a step every enabled cycle, wrap once per 16 cycles.
    task automatic test_dwell1();
        out_b_t e, o;
        int n = 0;
        logic [15:0] one = 16'b1;
        logic [3:0]  ei;
        en_b = 1'b1; mode_b = M_SCAN; x_b = 4'd14; load_b = 1'b1;
        exp_b_q.push_back(out_b_t'({one << 14, 4'd14, 1'b0}));
        @(posedge clk); #1;
        obs_b_q.push_back(out_b_t'({y_b, idx_b, wrap_b}));
        load_b = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            ei = 4'(14 + k);
            exp_b_q.push_back(out_b_t'({one << ei, ei, (ei == 4'd0)}));
            @(posedge clk); #1;
            obs_b_q.push_back(out_b_t'({y_b, idx_b, wrap_b}));
        end
        while (exp_b_q.size() > 0) begin
            e = exp_b_q.pop_front(); o = obs_b_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL dwell1[%0d]: got Y=%h idx=%0d wrap=%b, want Y=%h idx=%0d wrap=%b",
                         n, o.y, o.idx, o.wrap, e.y, e.idx, e.wrap);
            end
            n++;
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0; load = 1'b0; mode = M_DEC; X = '0;
        en_b = 1'b0; load_b = 1'b0; mode_b = M_DEC; x_b = '0;
        @(posedge clk); #1;
        test_reset();
        test_decode();
        test_therm();
        test_scan();
        test_back_to_back();
        test_mode_entry();
        test_reset_midscan();
        test_dwell1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
